// File: rtl/pipeline_pkg.sv
// Shared definitions for the video pipeline.
//   - Foreground scale encoding, used by this writer and the read-side scaler.
//   - Default frame geometry and pixel width.
//   - Helper to size an SRAM word address for a given frame.
package pipeline_pkg;

  typedef logic [1:0] scale_t;

  localparam scale_t SCALE_FULL    = 2'b11;
  localparam scale_t SCALE_HALF    = 2'b10;
  localparam scale_t SCALE_QUARTER = 2'b01;
  localparam scale_t SCALE_OFF     = 2'b00;

  localparam int RESOLUTION_X_DEFAULT = 800;
  localparam int RESOLUTION_Y_DEFAULT = 600;
  localparam int PIXEL_WIDTH_DEFAULT  = 12;
  localparam int PRECISION_DEFAULT    = 10;

  // Smallest word-address width that covers every pixel of a res_x*res_y frame.
  function automatic int addr_width_for(input int res_x, input int res_y);
    return $clog2(res_x * res_y);
  endfunction

endpackage

// File: rtl/pipeline_foreground_writer_if.sv
// SRAM write-request channel between a pixel writer and the memory arbiter.
//   wr_valid  request pending (writer -> arbiter)
//   wr_ready  arbiter accepts the pending request this cycle
//   wr_addr   SRAM word address
//   wr_data   pixel data
// master = request source (writer), slave = arbiter side.
interface pipeline_foreground_writer_if
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH  = addr_width_for(RESOLUTION_X_DEFAULT, RESOLUTION_Y_DEFAULT),
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT
);

  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [PIXEL_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/pipeline_foreground_writer_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst    clock, asynchronous active-high reset (empties the FIFO)
//   push        write push_data (ignored when full unless a pop happens the same cycle)
//   push_data   entry to store
//   pop         remove the head entry (ignored when empty)
//   head_data   current head entry, zero while empty
//   full/empty  occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  PTR_ONE = 1;

  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can be accepted.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage has no reset; stale words are never visible because the head
  // output is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_data;
  end

  assign head_data = empty ? '0 : mem_reg[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/pipeline_foreground_writer.sv
// Foreground frame-buffer write side.
// Filters the incoming foreground pixel stream down to the pixels the read-side
// scaler will fetch, converts (x,y) to an SRAM word address and queues write
// requests toward the memory arbiter. The video input is never stalled: when the
// queue is full, the pixel is dropped and recorded in overflow/drop_count.
//   clk, rst                clock, asynchronous active-high reset
//   ctrl_foreground_scale   11 full, 10 half, 01 quarter, 00 off (latched at pixel (0,0))
//   in_valid/in_pixel_x/in_pixel_y/in_pixel   input pixel stream
//   wr                      write-request channel (master side)
//   overflow                sticky: some pixel has been dropped
//   drop_count              dropped pixels, saturating at 16'hFFFF
module pipeline_foreground_writer
  import pipeline_pkg::*;
#(
  parameter int RESOLUTION_X = RESOLUTION_X_DEFAULT,
  parameter int RESOLUTION_Y = RESOLUTION_Y_DEFAULT,
  parameter int PRECISION    = PRECISION_DEFAULT,
  parameter int PIXEL_WIDTH  = PIXEL_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH   = addr_width_for(RESOLUTION_X, RESOLUTION_Y),
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             ctrl_foreground_scale,
  input  logic                   in_valid,
  input  logic [PRECISION-1:0]   in_pixel_x,
  input  logic [PRECISION-1:0]   in_pixel_y,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  pipeline_foreground_writer_if.master wr,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int                    ENTRY_W    = ADDR_WIDTH + PIXEL_WIDTH;
  localparam logic [PRECISION:0]    RES_X_LIM  = (PRECISION+1)'(RESOLUTION_X);
  localparam logic [PRECISION:0]    RES_Y_LIM  = (PRECISION+1)'(RESOLUTION_Y);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(RESOLUTION_X);

  // ---------------------------------------------------------------------------
  // Selection on the raw input
  // ---------------------------------------------------------------------------
  scale_t                scale_reg;
  scale_t                scale_next;
  logic                  frame_start;
  logic                  in_range;
  logic                  on_grid;
  logic                  select;
  logic [ADDR_WIDTH-1:0] pixel_addr;

  always_comb begin
    frame_start = in_valid && (in_pixel_x == '0) && (in_pixel_y == '0);
    // Pixel (0,0) is judged with the scale it is latching, so a new scale
    // takes effect from the first pixel of the frame.
    scale_next  = frame_start ? ctrl_foreground_scale : scale_reg;
    in_range    = ({1'b0, in_pixel_x} < RES_X_LIM) && ({1'b0, in_pixel_y} < RES_Y_LIM);

    on_grid = 1'b0;
    case (scale_next)
      SCALE_FULL:    on_grid = 1'b1;
      SCALE_HALF:    on_grid = !in_pixel_x[0] && !in_pixel_y[0];
      SCALE_QUARTER: on_grid = (in_pixel_x[1:0] == 2'b00) && (in_pixel_y[1:0] == 2'b00);
      default:       on_grid = 1'b0;
    endcase

    select     = in_valid && in_range && on_grid;
    pixel_addr = ADDR_WIDTH'(in_pixel_y) * ROW_STRIDE + ADDR_WIDTH'(in_pixel_x);
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered address/data of the selected pixel
  // ---------------------------------------------------------------------------
  logic                   s1_valid_reg;
  logic [ADDR_WIDTH-1:0]  s1_addr_reg;
  logic [PIXEL_WIDTH-1:0] s1_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale_reg    <= SCALE_OFF;
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      s1_data_reg  <= '0;
    end else begin
      if (frame_start) scale_reg <= ctrl_foreground_scale;
      s1_valid_reg <= select;
      if (select) begin
        s1_addr_reg <= pixel_addr;
        s1_data_reg <= in_pixel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: write queue toward the arbiter
  // ---------------------------------------------------------------------------
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  assign fifo_pop = wr.wr_valid && wr.wr_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_valid_reg),
    .push_data ({s1_addr_reg, s1_data_reg}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr.wr_valid = !fifo_empty;
  assign wr.wr_addr  = fifo_head[ENTRY_W-1:PIXEL_WIDTH];
  assign wr.wr_data  = fifo_head[PIXEL_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Drop accounting: a pixel is lost only when the queue is full and the
  // arbiter is not taking the head in the same cycle.
  // ---------------------------------------------------------------------------
  logic        drop;
  logic        overflow_reg;
  logic [15:0] drop_count_reg;
  logic [15:0] drop_count_next;

  assign drop = s1_valid_reg && fifo_full && !fifo_pop;

  always_comb begin
    drop_count_next = drop_count_reg;
    if (drop && (drop_count_reg != 16'hFFFF)) drop_count_next = drop_count_reg + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (drop) overflow_reg <= 1'b1;
      drop_count_reg <= drop_count_next;
    end
  end

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_pipeline_foreground_writer.sv
// Self-checking bench for pipeline_foreground_writer.
// A queue-based model (selected pixels -> one-cycle register -> bounded queue)
// predicts every cycle's wr_valid/head/overflow/drop_count; directed steps and a
// randomized phase drive the DUT. The frame height is reduced so a complete
// frame stays short; the row stride remains 800.
module tb_pipeline_foreground_writer;
  import pipeline_pkg::*;

  localparam int RX    = 800;
  localparam int RY    = 24;
  localparam int PREC  = 10;
  localparam int PW    = 12;
  localparam int AW    = 19;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      ctrl;
  logic            in_valid;
  logic [PREC-1:0] in_x;
  logic [PREC-1:0] in_y;
  logic [PW-1:0]   in_p;
  logic            overflow;
  logic [15:0]     drop_count;

  pipeline_foreground_writer_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) wr_bus ();

  pipeline_foreground_writer #(
    .RESOLUTION_X (RX),
    .RESOLUTION_Y (RY),
    .PRECISION    (PREC),
    .PIXEL_WIDTH  (PW),
    .ADDR_WIDTH   (AW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ctrl_foreground_scale (ctrl),
    .in_valid              (in_valid),
    .in_pixel_x            (in_x),
    .in_pixel_y            (in_y),
    .in_pixel              (in_p),
    .wr                    (wr_bus.master),
    .overflow              (overflow),
    .drop_count            (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
  } ent_t;

  // reference model state
  ent_t   q[$];
  bit     pend_v;
  ent_t   pend;
  logic [1:0] frame_scale;
  int     m_drops;
  bit     m_ovf;

  // observed write log
  int     writes;
  int     last_addr;
  int     wlog[$];
  bit     log_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input logic [1:0] s);
    case (s)
      SCALE_FULL:    return 1;
      SCALE_HALF:    return 2;
      SCALE_QUARTER: return 4;
      default:       return 0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    pend_v      = 1'b0;
    frame_scale = SCALE_OFF;
    m_drops     = 0;
    m_ovf       = 1'b0;
  endtask

  task automatic check_outputs();
    chk("wr_valid", 32'(wr_bus.wr_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("wr_addr", 32'(wr_bus.wr_addr), 32'(q[0].addr));
      chk("wr_data", 32'(wr_bus.wr_data), 32'(q[0].data));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  // One clock cycle: check outputs, apply inputs, advance the model, wait.
  task automatic drive(input bit v, input int x, input int y, input logic [PW-1:0] p, input bit rdy);
    bit pop;
    bit was_full;
    int st;
    check_outputs();
    if (wr_bus.wr_valid === 1'b1 && rdy) begin
      writes++;
      last_addr = int'(wr_bus.wr_addr);
      wlog.push_back(int'(wr_bus.wr_addr));
      if (log_en) $display("write addr %0d data %03h", wr_bus.wr_addr, wr_bus.wr_data);
    end
    in_valid       = v;
    in_x           = PREC'(x);
    in_y           = PREC'(y);
    in_p           = p;
    wr_bus.wr_ready = rdy;

    pop      = (q.size() > 0) && rdy;
    was_full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (pend_v) begin
      if (was_full && !pop) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end else begin
        q.push_back(pend);
      end
    end
    if (v && x == 0 && y == 0) frame_scale = ctrl;
    st = step_of(frame_scale);
    pend_v = 1'b0;
    if (v && x < RX && y < RY && st != 0) pend_v = (x % st == 0) && (y % st == 0);
    pend.addr = y * RX + x;
    pend.data = int'(p);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drive(1'b0, 0, 0, '0, rdy);
  endtask

  task automatic chk_log(input string tag, input int exp[]);
    chk({tag, "_count"}, 32'(wlog.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < wlog.size()) chk({tag, "_addr"}, 32'(wlog[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int exp_half[];
    int exp_quarter[];
    int exp_list[];
    logic [PW-1:0] p0;

    ctrl            = SCALE_FULL;
    in_valid        = 1'b0;
    in_x            = '0;
    in_y            = '0;
    in_p            = '0;
    wr_bus.wr_ready = 1'b1;
    writes          = 0;
    last_addr       = -1;
    log_en          = 1'b0;
    model_reset();

    // 1. reset with random input activity
    rst = 1'b1;
    repeat (4) begin
      in_valid = 1'($urandom);
      in_x     = PREC'($urandom);
      in_y     = PREC'($urandom);
      in_p     = PW'($urandom);
      @(negedge clk);
      chk("rst_wr_valid", 32'(wr_bus.wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(wr_bus.wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_bus.wr_data), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
    end
    rst = 1'b0;
    model_reset();
    $display("step reset: released");
    drive(1'b1, 0, 0, 12'hABC, 1'b1);
    drive(1'b0, 0, 0, '0, 1'b1);
    chk("lat_wr_valid", 32'(wr_bus.wr_valid), 32'd1);
    chk("lat_wr_addr", 32'(wr_bus.wr_addr), 32'd0);
    chk("lat_wr_data", 32'(wr_bus.wr_data), 32'hABC);
    $display("step latency: pixel (0,0) presented two edges after sampling");
    idle(4, 1'b1);

    // 2. complete frame at full scale plus out-of-range pixels
    writes = 0;
    ctrl   = SCALE_FULL;
    for (int y = 0; y < RY; y++)
      for (int x = 0; x < RX; x++)
        drive(1'b1, x, y, PW'($urandom), 1'b1);
    drive(1'b1, RX, 0, PW'($urandom), 1'b1);
    drive(1'b1, RX + 3, 5, PW'($urandom), 1'b1);
    drive(1'b1, 0, RY, PW'($urandom), 1'b1);
    drive(1'b1, 5, RY + 1, PW'($urandom), 1'b1);
    idle(6, 1'b1);
    chk("frame_writes", 32'(writes), 32'(RX * RY));
    chk("frame_last_addr", 32'(last_addr), 32'(RX * RY - 1));
    chk("frame_drops", 32'(drop_count), 32'd0);
    $display("step full frame: %0d writes, last addr %0d", writes, last_addr);

    // 3. half and quarter scale over rows 0..3, x 0..7
    log_en = 1'b1;
    exp_half    = '{0, 2, 4, 6, 1600, 1602, 1604, 1606};
    exp_quarter = '{0, 4};
    wlog.delete();
    ctrl = SCALE_HALF;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        drive(1'b1, x, y, PW'($urandom), 1'b1);
    idle(4, 1'b1);
    chk_log("half", exp_half);
    $display("step half scale: %0d writes", wlog.size());
    wlog.delete();
    ctrl = SCALE_QUARTER;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        drive(1'b1, x, y, PW'($urandom), 1'b1);
    idle(4, 1'b1);
    chk_log("quarter", exp_quarter);
    $display("step quarter scale: %0d writes", wlog.size());

    // 4. scale change mid-frame only takes effect at next (0,0)
    log_en = 1'b0;
    wlog.delete();
    ctrl = SCALE_FULL;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 8; x++) begin
        if (x == 5 && y == 3) ctrl = SCALE_HALF;
        drive(1'b1, x, y, PW'($urandom), 1'b1);
      end
    idle(4, 1'b1);
    chk("midframe_writes", 32'(wlog.size()), 32'd40);
    $display("step mid-frame scale change: %0d writes in old frame", wlog.size());
    log_en = 1'b1;
    wlog.delete();
    exp_list = '{0, 2};
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        drive(1'b1, x, y, PW'($urandom), 1'b1);
    idle(4, 1'b1);
    chk_log("newframe_half", exp_list);

    // 5. backpressure: 20 pixels with the arbiter stalled
    wlog.delete();
    ctrl = SCALE_FULL;
    p0   = PW'($urandom);
    drive(1'b1, 0, 0, p0, 1'b0);
    for (int x = 1; x < 20; x++) drive(1'b1, x, 0, PW'($urandom), 1'b0);
    idle(2, 1'b0);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_drop_count", 32'(drop_count), 32'd12);
    chk("bp_wr_valid", 32'(wr_bus.wr_valid), 32'd1);
    chk("bp_head_addr", 32'(wr_bus.wr_addr), 32'd0);
    chk("bp_head_data", 32'(wr_bus.wr_data), 32'(p0));
    $display("step backpressure: drop_count %0d", drop_count);
    idle(10, 1'b1);
    exp_list = '{0, 1, 2, 3, 4, 5, 6, 7};
    chk_log("bp_drain", exp_list);

    // 6. full queue with simultaneous push and pop, then async reset pulse
    wlog.delete();
    for (int x = 0; x < 9; x++) drive(1'b1, x, 1, PW'($urandom), 1'b0);
    for (int x = 9; x < 19; x++) drive(1'b1, x, 1, PW'($urandom), 1'b1);
    idle(12, 1'b1);
    exp_list = new[19];
    foreach (exp_list[i]) exp_list[i] = RX + i;
    chk_log("pushpop", exp_list);
    chk("pushpop_drops", 32'(drop_count), 32'd12);
    $display("step push+pop while full: %0d writes", wlog.size());

    for (int x = 0; x < 4; x++) drive(1'b1, x, 2, PW'($urandom), 1'b0);
    chk("pre_rst_wr_valid", 32'(wr_bus.wr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr_valid", 32'(wr_bus.wr_valid), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    chk("async_rst_drop_count", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("step async reset pulse: released");
    log_en = 1'b0;
    wlog.delete();
    idle(5, 1'b1);
    chk("post_rst_writes", 32'(wlog.size()), 32'd0);
    ctrl = SCALE_FULL;
    drive(1'b1, 0, 0, PW'($urandom), 1'b1);
    idle(4, 1'b1);
    exp_list = '{0};
    chk_log("post_rst_first", exp_list);

    // 7. randomized frames: random scale, gaps, stalls, out-of-range pixels
    for (int f = 0; f < 6; f++) begin
      ctrl = 2'($urandom_range(0, 3));
      for (int y = 0; y < 9; y++)
        for (int x = 0; x < 18; x++) begin
          int xc;
          int yc;
          bit v;
          xc = (x < 16) ? x : RX + x - 16;
          yc = (y < 8) ? y : RY + 1;
          v  = (x == 0 && y == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          drive(v, xc, yc, PW'($urandom), 1'($urandom_range(0, 1)));
        end
      idle(12, 1'b1);
      $display("step random frame %0d: scale %0b, drop_count %0d", f, ctrl, drop_count);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
